// File: rtl/gradient_frame_sequencer.sv
// gradient_frame_sequencer: raster-scans one frame out of a pair of ping-pong
// frame buffers per start request, aligns returned current/previous pixels
// with their coordinates, waits for the gradient datapath to drain, then
// swaps bank roles and pulses done.
// Optional build macro: GSEQ_SKIP_FIRST_EN (first start after reset only
// swaps banks, because no previous frame exists yet).
module gradient_frame_sequencer #(
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 240,
    parameter int PIXEL_WIDTH  = 8,
    parameter int RD_LATENCY   = 1,
    parameter int DRAIN_CYCLES = 2*WIDTH+8,
    parameter int ADDR_W       = $clog2(WIDTH*HEIGHT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [PIXEL_WIDTH-1:0] rd_data_b0,
    input  logic [PIXEL_WIDTH-1:0] rd_data_b1,
    output logic                   curr_bank,
    output logic [PIXEL_WIDTH-1:0] pixel_curr,
    output logic [PIXEL_WIDTH-1:0] pixel_prev,
    output logic                   pixel_valid,
    output logic [9:0]             pixel_x,
    output logic [8:0]             pixel_y,
    output logic [15:0]            frame_count
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t          state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [DW-1:0]   drain_cnt;

    logic            last_pos;
    logic            accept;
    logic            launch;
    logic            skip;
    logic            finish;

`ifdef GSEQ_SKIP_FIRST_EN
    logic            primed;
`endif

    // Read-return alignment pipeline: one entry per cycle of read latency.
    logic            v_pipe [RD_LATENCY];
    logic [XW-1:0]   x_pipe [RD_LATENCY];
    logic [YW-1:0]   y_pipe [RD_LATENCY];
    logic            b_pipe [RD_LATENCY];

    // Decode frame-level events: acceptance, skipped first frame, completion.
    always_comb begin
        last_pos = (x == XW'(WIDTH-1)) && (y == YW'(HEIGHT-1));
        // A start in the done cycle is not taken; earliest restart is the cycle after.
        accept   = (state == IDLE) && start && !abort && !done;
`ifdef GSEQ_SKIP_FIRST_EN
        skip     = accept && !primed;
`else
        skip     = 1'b0;
`endif
        launch   = accept && !skip;
        finish   = 1'b0;
        if (!abort) begin
            // Single-cycle drain completes on the very edge that leaves STREAM.
            if ((state == STREAM) && last_pos && (DRAIN_CYCLES == 1)) begin
                finish = 1'b1;
            end
            if ((state == DRAIN) && (drain_cnt == DW'(1))) begin
                finish = 1'b1;
            end
        end
    end

    // Frame FSM with registered control outputs and running address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            x           <= '0;
            y           <= '0;
            drain_cnt   <= '0;
            curr_bank   <= 1'b0;
            frame_count <= '0;
`ifdef GSEQ_SKIP_FIRST_EN
            primed      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state   <= STREAM;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        x       <= '0;
                        y       <= '0;
                    end
                end
                STREAM: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        rd_en <= 1'b0;
                    end else if (last_pos) begin
                        state     <= DRAIN;
                        rd_en     <= 1'b0;
                        drain_cnt <= DW'(DRAIN_CYCLES-1);
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        if (x == XW'(WIDTH-1)) begin
                            x <= '0;
                            y <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        rd_en <= 1'b0;
                    end else if (drain_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    rd_en <= 1'b0;
                end
            endcase

            // done/busy/bank/count are registered one edge early so they
            // become visible in the cycle the drain counter reads zero.
            if (finish) begin
                done        <= 1'b1;
                busy        <= 1'b0;
                curr_bank   <= ~curr_bank;
                frame_count <= frame_count + 16'd1;
            end

`ifdef GSEQ_SKIP_FIRST_EN
            if (skip) begin
                primed    <= 1'b1;
                done      <= 1'b1;
                curr_bank <= ~curr_bank;
            end
`endif
        end
    end

    // Delay read strobe, coordinates and bank select by the read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                v_pipe[i] <= 1'b0;
                x_pipe[i] <= '0;
                y_pipe[i] <= '0;
                b_pipe[i] <= 1'b0;
            end
        end else begin
            v_pipe[0] <= rd_en;
            x_pipe[0] <= x;
            y_pipe[0] <= y;
            b_pipe[0] <= curr_bank;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                x_pipe[i] <= x_pipe[i-1];
                y_pipe[i] <= y_pipe[i-1];
                b_pipe[i] <= b_pipe[i-1];
            end
            // Cancelled reads still in flight must never reach the datapath.
            if (abort && (state != IDLE)) begin
                for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                    v_pipe[i] <= 1'b0;
                end
            end
        end
    end

    // Present returned data: current bank to pixel_curr, the other to pixel_prev.
    always_comb begin
        pixel_valid = v_pipe[RD_LATENCY-1];
        pixel_x     = 10'(x_pipe[RD_LATENCY-1]);
        pixel_y     = 9'(y_pipe[RD_LATENCY-1]);
        pixel_curr  = '0;
        pixel_prev  = '0;
        if (v_pipe[RD_LATENCY-1]) begin
            if (b_pipe[RD_LATENCY-1]) begin
                pixel_curr = rd_data_b1;
                pixel_prev = rd_data_b0;
            end else begin
                pixel_curr = rd_data_b0;
                pixel_prev = rd_data_b1;
            end
        end
    end

endmodule
